// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with runtime parity, framing
// error detection and false-start rejection. Samples are taken on the
// shared oversampling baud tick.
// Optional build macro: UART_RX_MAJVOTE_EN enables 2-of-3 majority voting
// on every start/data/parity/stop sample; undefined gives single sampling.
module uart_rx_param #(
    parameter int unsigned DBITS       = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SB_TICKS    = 16,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic             I_CLK,
    input  logic             I_RSTF,
    input  logic             I_RX,
    input  logic             I_BAUD_TICK,
    input  logic             I_PAR_EN,
    input  logic             I_PAR_ODD,
    output logic [DBITS-1:0] O_DATA,
    output logic             O_RX_DONE,
    output logic             O_PAR_ERR,
    output logic             O_FRM_ERR,
    output logic             O_BUSY
);

    localparam int unsigned S_MAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
    localparam int unsigned S_W   = $clog2(S_MAX);
    localparam int unsigned B_W   = $clog2(DBITS);

    localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_FULL = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICKS - 1);
    localparam logic [B_W-1:0] B_LAST = B_W'(DBITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [S_W-1:0]         r_s;
    logic [B_W-1:0]         r_b;
    logic [DBITS-1:0]       r_d;
    logic                   r_par_en;
    logic                   r_par_odd;
    logic                   r_par_err;
    logic [DBITS-1:0]       r_data;
    logic                   r_done;
    logic                   r_perr_out;
    logic                   r_ferr_out;
    logic                   r_busy;

    logic                   w_rx;
    logic                   w_bit;
    logic [S_W-1:0]         w_last;

    assign w_rx = r_sync[SYNC_STAGES-1];

    // Bring the asynchronous line into the clock domain; resets to idle-high
    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], I_RX};
        end
    end

    // Terminal sample-count value for the current state
    always_comb begin
        w_last = S_FULL;
        case (r_state)
            ST_START: w_last = S_HALF;
            ST_STOP:  w_last = S_STOP;
            default:  w_last = S_FULL;
        endcase
    end

`ifdef UART_RX_MAJVOTE_EN
    logic [1:0] r_vote;

    // Capture the two samples preceding the decision tick for the vote
    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            r_vote <= 2'b11;
        end else if (I_BAUD_TICK && (r_state != ST_IDLE)) begin
            if (r_s == (w_last - S_W'(2))) r_vote[0] <= w_rx;
            if (r_s == (w_last - S_W'(1))) r_vote[1] <= w_rx;
        end
    end

    assign w_bit = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rx) | (r_vote[1] & w_rx);
`else
    assign w_bit = w_rx;
`endif

    // Frame FSM: counts ticks per state, assembles the word, registers results
    always_ff @(posedge I_CLK or negedge I_RSTF) begin
        if (!I_RSTF) begin
            r_state    <= ST_IDLE;
            r_s        <= '0;
            r_b        <= '0;
            r_d        <= '0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_par_err  <= 1'b0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (!w_rx) begin
                    r_state   <= ST_START;
                    r_s       <= '0;
                    r_par_en  <= I_PAR_EN;
                    r_par_odd <= I_PAR_ODD;
                    r_par_err <= 1'b0;
                    r_busy    <= 1'b1;
                end
            end else if (I_BAUD_TICK) begin
                if (r_s != w_last) begin
                    r_s <= r_s + S_W'(1);
                end else begin
                    r_s <= '0;
                    case (r_state)
                        ST_START: begin
                            if (!w_bit) begin
                                r_state <= ST_DATA;
                                r_b     <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                        ST_DATA: begin
                            r_d <= {w_bit, r_d[DBITS-1:1]};
                            if (r_b == B_LAST) begin
                                r_state <= r_par_en ? ST_PARITY : ST_STOP;
                            end else begin
                                r_b <= r_b + B_W'(1);
                            end
                        end
                        ST_PARITY: begin
                            r_par_err <= w_bit ^ (^r_d) ^ r_par_odd;
                            r_state   <= ST_STOP;
                        end
                        ST_STOP: begin
                            r_data     <= r_d;
                            r_perr_out <= r_par_err;
                            r_ferr_out <= ~w_bit;
                            r_done     <= 1'b1;
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign O_DATA    = r_data;
    assign O_RX_DONE = r_done;
    assign O_PAR_ERR = r_perr_out;
    assign O_FRM_ERR = r_ferr_out;
    assign O_BUSY    = r_busy;

endmodule
